// File: rtl/systolic_seq_pkg.sv
// Shared definitions for the systolic array tile sequencer: state encoding and default geometry.
// The overlapped-readout variant is selected with SEQ_OVERLAP_EN in the top-level module.
package systolic_seq_pkg;

   localparam int SLICES_DEF   = 4;
   localparam int KW_DEF       = 8;
   localparam int PIPE_LAT_DEF = 2;
   localparam int N_OUT        = 2 * SLICES_DEF * SLICES_DEF;
   localparam int IDX_W        = $clog2(N_OUT);
   localparam int BEAT_W       = KW_DEF + $clog2(SLICES_DEF);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FLUSH,
      ST_WAIT,
      ST_COPY,
      ST_READOUT
   } seq_state_t;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that stops at zero; load has priority over the count enable.
module seq_down_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (en && !zero)
         count <= count - W'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/systolic_array_sequencer.sv
// Tile control FSM for the fp4 x i8 systolic array: accumulator reset, operand window, flush, copy, readout.
// Define SEQ_OVERLAP_EN to accept the next tile during READOUT and overlap its LOAD/FLUSH with the readout.
module systolic_array_sequencer
   import systolic_seq_pkg::*;
#(
   parameter int SLICES   = SLICES_DEF,
   parameter int KW       = KW_DEF,
   parameter int PIPE_LAT = PIPE_LAT_DEF
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [KW-1:0]                        k_len,
   output logic                                 start_ready,
   output logic                                 in_ready,
   output logic                                 out_valid,
   output logic [$clog2(2*SLICES*SLICES)-1:0]   out_index,
   output logic                                 out_last,
   output logic                                 done,
   output logic                                 busy,
   output logic                                 arr_restart_inputs,
   output logic                                 arr_reset_acc,
   output logic                                 arr_copy_out,
   output logic                                 arr_restart_out
);

   localparam int OUT_BEATS = 2 * SLICES * SLICES;
   localparam int IDX_BITS  = $clog2(OUT_BEATS);
   localparam int BEAT_BITS = KW + $clog2(SLICES);

   seq_state_t           state;
   logic                 accept;
   logic                 rd_active;
   logic                 beat_load;
   logic                 beat_zero;
   logic                 rd_zero;
   logic [BEAT_BITS-1:0] beat_value;
   logic [BEAT_BITS-1:0] beat_count;
   logic [IDX_BITS-1:0]  rd_count;

`ifdef SEQ_OVERLAP_EN
   assign start_ready = (state == ST_IDLE) || (state == ST_READOUT);
`else
   assign start_ready = (state == ST_IDLE);
`endif

   // Reset masks accept so no pulse escapes while the sequencer is being cleared.
   assign accept     = start && start_ready && (k_len != '0) && !reset;
   assign beat_load  = accept || ((state == ST_LOAD) && beat_zero);
   assign beat_value = accept ? (BEAT_BITS'(k_len) * BEAT_BITS'(SLICES)) - BEAT_BITS'(1)
                              : BEAT_BITS'(PIPE_LAT - 1);

   seq_down_counter #(.W(BEAT_BITS)) u_beat_cnt (
      .clk        (clk),
      .reset      (reset),
      .load       (beat_load),
      .load_value (beat_value),
      .en         ((state == ST_LOAD) || (state == ST_FLUSH)),
      .count      (beat_count),
      .zero       (beat_zero)
   );

   // The readout counter runs off rd_active rather than the state so a new tile can load underneath it.
   seq_down_counter #(.W(IDX_BITS)) u_readout_cnt (
      .clk        (clk),
      .reset      (reset),
      .load       (state == ST_COPY),
      .load_value (IDX_BITS'(OUT_BEATS - 1)),
      .en         (rd_active),
      .count      (rd_count),
      .zero       (rd_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         rd_active <= 1'b0;
      end else begin
         if (state == ST_COPY)
            rd_active <= 1'b1;
         else if (out_last)
            rd_active <= 1'b0;

         case (state)
            ST_IDLE:    if (accept) state <= ST_LOAD;
            ST_LOAD:    if (beat_zero) state <= ST_FLUSH;
`ifdef SEQ_OVERLAP_EN
            ST_FLUSH:   if (beat_zero) state <= (rd_active && !rd_zero) ? ST_WAIT : ST_COPY;
`else
            ST_FLUSH:   if (beat_zero) state <= ST_COPY;
`endif
            ST_WAIT:    if (out_last) state <= ST_COPY;
            ST_COPY:    state <= ST_READOUT;
            ST_READOUT: begin
               if (accept)
                  state <= ST_LOAD;
               else if (out_last)
                  state <= ST_IDLE;
            end
            default:    state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready           = (state == ST_LOAD);
   assign busy               = (state != ST_IDLE);
   assign out_valid          = rd_active;
   assign out_last           = rd_active && rd_zero;
   assign done               = out_last;
   assign out_index          = rd_active ? (IDX_BITS'(OUT_BEATS - 1) - rd_count) : '0;
   assign arr_restart_inputs = accept;
   assign arr_reset_acc      = accept;
   assign arr_copy_out       = (state == ST_COPY);
   assign arr_restart_out    = (state == ST_COPY);

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Directed self-checking bench for systolic_array_sequencer (SLICES=4, PIPE_LAT=2, N_OUT=32).
// Define SEQ_OVERLAP_EN for both bench and RTL to exercise the overlapped-readout tile.
module tb_systolic_array_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b1;
   logic [7:0] k_len = 8'd1;
   logic       start_ready, in_ready, out_valid, out_last, done, busy;
   logic [4:0] out_index;
   logic       arr_restart_inputs, arr_reset_acc, arr_copy_out, arr_restart_out;

   int vectors = 0;
   int miscompares = 0;

`ifdef SEQ_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   always #5 clk = ~clk;

   systolic_array_sequencer dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .k_len              (k_len),
      .start_ready        (start_ready),
      .in_ready           (in_ready),
      .out_valid          (out_valid),
      .out_index          (out_index),
      .out_last           (out_last),
      .done               (done),
      .busy               (busy),
      .arr_restart_inputs (arr_restart_inputs),
      .arr_reset_acc      (arr_reset_acc),
      .arr_copy_out       (arr_copy_out),
      .arr_restart_out    (arr_restart_out)
   );

   function automatic logic [14:0] observedVec();
      return {start_ready, in_ready, out_valid, out_index, out_last, done, busy,
              arr_restart_inputs, arr_reset_acc, arr_copy_out, arr_restart_out};
   endfunction

   function automatic logic [14:0] expVec(input bit sr, input bit ir, input bit ov, input int idx,
                                          input bit last, input bit bz, input bit pulse, input bit cp);
      logic [4:0] i5;
      i5 = 5'(idx);
      return {sr, ir, ov, i5, last, last, bz, pulse, pulse, cp, cp};
   endfunction

   task automatic applyStimulus(input bit s, input int k, input bit r);
      @(negedge clk);
      start = s;
      k_len = 8'(k);
      reset = r;
      #1;
   endtask

   task automatic checkOutput(input string tag, input int cyc, input logic [14:0] observed,
                              input logic [14:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s cycle %0d observed=%b expected=%b", tag, cyc, observed, expected);
      end
   endtask

   // Runs one tile from its accept cycle (c=0); expectations follow the fixed latency k*4+PIPE_LAT+2.
   task automatic runTile(input int k, input int pokeAt, input int abortAt, input string tag);
      int inrCount;
      bit ir, ov, last, bz, sr;
      int idx;
      inrCount = 0;
      for (int c = 0; c <= 4*k + 36; c++) begin
         applyStimulus((c == 0) || (c == pokeAt), (c == 0) ? k : 1, (c == abortAt));
         ir   = (c >= 1) && (c <= 4*k);
         ov   = (c >= 4*k + 4) && (c <= 4*k + 35);
         idx  = ov ? c - (4*k + 4) : 0;
         last = (c == 4*k + 35);
         bz   = (c >= 1) && (c <= 4*k + 35);
         sr   = (c == 0) || !bz || (OVL && ov);
         if (in_ready) inrCount++;
         checkOutput(tag, c, observedVec(), expVec(sr, ir, ov, idx, last, bz, c == 0, c == 4*k + 3));
         if (c == abortAt) break;
      end
      if (abortAt < 0)
         checkOutput({tag, "_inready_count"}, 0, 15'(inrCount), 15'(4*k));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset held with start=1: idle outputs, no accept pulses.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checkOutput("reset_hold", i, observedVec(), expVec(1, 0, 0, 0, 0, 0, 0, 0));
      end

      // Release reset with start still high: accept in that cycle, then the k=1 timing.
      runTile(1, -1, -1, "k1_basic");

      // k_len=0 is ignored.
      applyStimulus(1, 0, 0);
      checkOutput("k0_ignored", 0, observedVec(), expVec(1, 0, 0, 0, 0, 0, 0, 0));
      applyStimulus(0, 0, 0);
      checkOutput("k0_still_idle", 1, observedVec(), expVec(1, 0, 0, 0, 0, 0, 0, 0));

      runTile(255, -1, -1, "k255");

      // Second start during LOAD must not disturb the k=3 tile.
      runTile(3, 5, -1, "k3_restart_ignored");

      // Synchronous reset at readout beat 10 of a k=1 tile.
      runTile(1, -1, 18, "k1_abort");
      applyStimulus(0, 1, 0);
      checkOutput("abort_idle", 0, observedVec(), expVec(1, 0, 0, 0, 0, 0, 0, 0));
      runTile(1, -1, -1, "after_abort");

`ifdef SEQ_OVERLAP_EN
      // Tile A (k=1) accepted at c=0, tile B (k=1) accepted at out_index=5 (c=13).
      for (int c = 0; c <= 73; c++) begin
         bit ir, ov, last, bz, sr, cp, pulse;
         int idx;
         applyStimulus((c == 0) || (c == 13), 1, 0);
         pulse = (c == 0) || (c == 13);
         ir    = ((c >= 1) && (c <= 4)) || ((c >= 14) && (c <= 17));
         cp    = (c == 7) || (c == 40);
         ov    = ((c >= 8) && (c <= 39)) || ((c >= 41) && (c <= 72));
         idx   = ((c >= 8) && (c <= 39)) ? c - 8 : ((c >= 41) && (c <= 72)) ? c - 41 : 0;
         last  = (c == 39) || (c == 72);
         bz    = (c >= 1) && (c <= 72);
         sr    = (c == 0) || ((c >= 8) && (c <= 13)) || (c >= 41);
         checkOutput("overlap", c, observedVec(), expVec(sr, ir, ov, idx, last, bz, pulse, cp));
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
